count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000, clock cycles between count enable pulses (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, stable cycles required to accept a button level change (>=1).
REQ-003 SHALL have parameter AUTO_STOP, default 0; 1 = stop at terminal count instead of wrapping.
REQ-004 SHALL have port clk, input, 1, system clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port btn_start_n, input, 1, raw asynchronous start/pause push button, active-low.
REQ-007 SHALL have port btn_dir_n, input, 1, raw asynchronous direction-toggle push button, active-low.
REQ-008 SHALL have port btn_clear_n, input, 1, raw asynchronous clear push button, active-low.
REQ-009 SHALL have port tc_up, input, 1, downstream counter at MODULO-1.
REQ-010 SHALL have port tc_down, input, 1, downstream counter at 1.
REQ-011 SHALL have port enable, output, 1, one-cycle count-step pulse to the counter.
REQ-012 SHALL have port up_down, output, 1, direction: 1 up, 0 down.
REQ-013 SHALL have port clear_n, output, 1, one-cycle active-low synchronous clear to the counter.
REQ-014 SHALL have port state, output, 2, FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.

Function
REQ-015 SHALL synchronise each button through a 2-FF synchroniser whose stages reset to 1.
REQ-016 SHALL hold a debounced level per button, reset to 1 (released); it SHALL take the synchronised value only after that value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-017 SHALL generate a one-cycle press event per button on a debounced 1->0 transition; release generates no event.
REQ-018 SHALL keep a prescaler div_cnt, width $clog2(CLK_DIV), counting 0..CLK_DIV-1 and wrapping only in RUN; held in PAUSE; forced to 0 in IDLE and DONE.
REQ-019 SHALL raise tick in RUN when div_cnt==CLK_DIV-1, at most once every CLK_DIV cycles.
REQ-020 SHALL drive enable=1 for exactly one cycle, the cycle after tick, except as suppressed by REQ-023.
REQ-021 SHALL make FSM transitions: IDLE--start-->RUN; RUN--start-->PAUSE; PAUSE--start-->RUN (div_cnt resumes from held value); DONE--start-->RUN (div_cnt from 0).
REQ-022 SHALL on a clear event in any state assert clear_n=0 for exactly one cycle (the next cycle), go to IDLE and zero div_cnt; clear has priority over start in the same cycle.
REQ-023 SHALL with AUTO_STOP=1, on a tick with (up_down=1 and tc_up=1) or (up_down=0 and tc_down=1), suppress enable and go to DONE; with AUTO_STOP=0 the tick always produces enable (downstream wraps).
REQ-024 SHALL toggle up_down on a direction event in any state; an enable issued in the same cycle carries the old direction, the new value appearing the following cycle.
REQ-025 SHALL register all outputs; no combinational path from any input to any output.
REQ-026 SHALL treat simultaneous start and direction events as both applied.

Reset
REQ-027 SHALL on reset=0 immediately force enable=0, up_down=1, clear_n=1, state=IDLE, div_cnt=0, debounce counters=0, debounced levels=1.
REQ-028 SHALL reach RUN after reset release only via a new debounced start press, even if btn_start_n is held low throughout reset.

Verification (CLK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-029 SHALL cover: start held low 10 cycles -> one press event, state 01, enable pulses every 4 cycles, up_down=1.
REQ-030 SHALL cover: 2-cycle low glitch on btn_start_n -> no event, state stays 00.
REQ-031 SHALL cover: RUN, start pressed again -> state 10, enable stops; third press -> state 01, next enable resumes from the held div_cnt.
REQ-032 SHALL cover: AUTO_STOP=1, RUN, up_down=1, tc_up=1 at tick -> no enable, state 11; clear press -> clear_n low one cycle, state 00.
REQ-033 SHALL cover: clear and start events in the same cycle while in RUN -> clear_n pulse, state 00.
REQ-034 SHALL cover: reset asserted mid-RUN with enable high -> enable 0, state 00, up_down 1 without waiting for a clock edge.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl: debounced start/pause, direction and clear buttons that drive a
// prescaled one-cycle count-enable pulse for an external up/down counter.
module count_ctrl #(
  parameter int CLK_DIV         = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int AUTO_STOP       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_n,
  input  logic       btn_dir_n,
  input  logic       btn_clear_n,
  input  logic       tc_up,
  input  logic       tc_down,
  output logic       enable,
  output logic       up_down,
  output logic       clear_n,
  output logic [1:0] state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button bit order throughout: {clear, dir, start}
  logic [2:0]            btn_raw_s;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            db_lvl_q, db_lvl_d;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]            press_s;

  logic [1:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  enable_q, enable_d;
  logic                  up_down_q, up_down_d;
  logic                  clear_n_q, clear_n_d;
  logic                  tick_s, stop_s;

  assign btn_raw_s = {btn_clear_n, btn_dir_n, btn_start_n};

  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    press_s  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        // Level accepted on the Nth consecutive disagreeing cycle.
        db_cnt_d[i] = '0;
        db_lvl_d[i] = sync2_q[i];
        press_s[i]  = ~sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    clear_n_d = 1'b1;
    up_down_d = up_down_q ^ press_s[1];
    tick_s    = (state_q == S_RUN) && (div_cnt_q == DIV_LAST);
    stop_s    = (AUTO_STOP != 0) && tick_s && (up_down_q ? tc_up : tc_down);
    enable_d  = tick_s & ~stop_s;
    case (state_q)
      S_RUN:   div_cnt_d = tick_s ? '0 : div_cnt_q + DIV_W'(1);
      S_PAUSE: div_cnt_d = div_cnt_q;
      default: div_cnt_d = '0;
    endcase
    // Clear wins over start; start wins over the terminal-count stop.
    if (press_s[2]) begin
      state_d   = S_IDLE;
      div_cnt_d = '0;
      clear_n_d = 1'b0;
    end else if (press_s[0]) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        S_DONE:  state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end else if (stop_s) begin
      state_d = S_DONE;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 3'b111;
      sync2_q   <= 3'b111;
      db_lvl_q  <= 3'b111;
      db_cnt_q  <= '0;
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      enable_q  <= 1'b0;
      up_down_q <= 1'b1;
      clear_n_q <= 1'b1;
    end else begin
      sync1_q   <= btn_raw_s;
      sync2_q   <= sync1_q;
      db_lvl_q  <= db_lvl_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      enable_q  <= enable_d;
      up_down_q <= up_down_d;
      clear_n_q <= clear_n_d;
    end
  end

  assign enable  = enable_q;
  assign up_down = up_down_q;
  assign clear_n = clear_n_q;
  assign state   = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: instance a wraps (AUTO_STOP=0), instance b stops
// at terminal count; expected values are queued and popped at each observation.
module tb_count_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_a, btn_b;  // {clear, dir, start}, active-low
  logic       tc_up_a, tc_down_a, tc_up_b, tc_down_b;
  logic       en_a, ud_a, clr_a, en_b, ud_b, clr_b;
  logic [1:0] st_a, st_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  count_ctrl #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .AUTO_STOP(0)) dut_a (
    .clk(clk), .reset(reset),
    .btn_start_n(btn_a[0]), .btn_dir_n(btn_a[1]), .btn_clear_n(btn_a[2]),
    .tc_up(tc_up_a), .tc_down(tc_down_a),
    .enable(en_a), .up_down(ud_a), .clear_n(clr_a), .state(st_a)
  );

  count_ctrl #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .AUTO_STOP(1)) dut_b (
    .clk(clk), .reset(reset),
    .btn_start_n(btn_b[0]), .btn_dir_n(btn_b[1]), .btn_clear_n(btn_b[2]),
    .tc_up(tc_up_b), .tc_down(tc_down_b),
    .enable(en_b), .up_down(ud_b), .clear_n(clr_b), .state(st_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic press(input bit b, input logic [2:0] m, input int hold);
    if (b) btn_b = btn_b & ~m; else btn_a = btn_a & ~m;
    step(hold);
    if (b) btn_b = btn_b | m; else btn_a = btn_a | m;
  endtask

  task automatic wait_en(input bit b, input int budget, output int c, output logic seen);
    seen = 1'b0;
    c    = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if ((b ? en_b : en_a) === 1'b1) begin
        seen = 1'b1;
        c    = cyc;
      end
    end
  endtask

  task automatic wait_clr(input bit b, input int budget, output int c, output logic seen);
    seen = 1'b0;
    c    = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if ((b ? clr_b : clr_a) === 1'b0) begin
        seen = 1'b1;
        c    = cyc;
      end
    end
  endtask

  task automatic quiet(input bit b, input int n, output logic any);
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if ((b ? en_b : en_a) !== 1'b0) any = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, c1, c2, c3, y, z, w;
    logic seen, any;

    btn_a = 3'b111; btn_b = 3'b111;
    tc_up_a = 1'b1; tc_down_a = 1'b1; tc_up_b = 1'b0; tc_down_b = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    step(3);
    expect_v("rst_en_a", 32'd0);  observe(en_a);
    expect_v("rst_ud_a", 32'd1);  observe(ud_a);
    expect_v("rst_clr_a", 32'd1); observe(clr_a);
    expect_v("rst_st_a", 32'd0);  observe(st_a);
    expect_v("rst_en_b", 32'd0);  observe(en_b);
    expect_v("rst_st_b", 32'd0);  observe(st_b);
    reset = 1'b1;
    step(2);

    // Two-cycle glitch must be rejected by the 3-cycle debounce.
    expect_v("glitch_st", 32'd0);
    press(1'b0, 3'b001, 2);
    step(8);
    observe(st_a);

    // Long press: one event, RUN, enable every 4 cycles, tc ignored when wrapping.
    t0 = cyc;
    expect_v("start_st", 32'd1);
    press(1'b0, 3'b001, 10);
    observe(st_a);
    expect_v("en1_seen", 32'd1);
    wait_en(1'b0, 8, c1, seen);
    observe(seen);
    expect_v("en1_phase", 32'd13);
    observe(c1 - t0);
    expect_v("en_width", 32'd0);
    step(1);
    observe(en_a);
    expect_v("en2_gap", 32'd4);
    wait_en(1'b0, 8, c2, seen);
    observe(c2 - c1);
    expect_v("en3_gap", 32'd4);
    wait_en(1'b0, 8, c3, seen);
    observe(c3 - c2);
    expect_v("run_ud", 32'd1);
    observe(ud_a);

    // Pause with div_cnt held at 1, then resume: enable 8 cycles after the press.
    expect_v("pause_st", 32'd2);
    press(1'b0, 3'b001, 5);
    observe(st_a);
    expect_v("pause_quiet", 32'd0);
    quiet(1'b0, 12, any);
    observe(any);
    y = cyc;
    expect_v("resume_st", 32'd1);
    press(1'b0, 3'b001, 5);
    observe(st_a);
    expect_v("resume_lat", 32'd8);
    wait_en(1'b0, 8, c1, seen);
    observe(c1 - y);

    expect_v("dir_ud", 32'd0);
    expect_v("dir_st", 32'd1);
    press(1'b0, 3'b010, 5);
    observe(ud_a);
    observe(st_a);

    // Clear and start together while running: clear wins.
    z = cyc;
    press(1'b0, 3'b101, 4);
    expect_v("clr_seen", 32'd1);
    wait_clr(1'b0, 4, c1, seen);
    observe(seen);
    expect_v("clr_lat", 32'd5);
    observe(c1 - z);
    expect_v("clr_st", 32'd0);
    observe(st_a);
    expect_v("clr_width", 32'd1);
    step(1);
    observe(clr_a);
    expect_v("clr_stay_idle", 32'd0);
    step(10);
    observe(st_a);

    // Asynchronous reset while enable is high.
    press(1'b0, 3'b001, 5);
    expect_v("pre_rst_seen", 32'd1);
    wait_en(1'b0, 8, c1, seen);
    observe(seen);
    reset = 1'b0;
    #1;
    expect_v("arst_en", 32'd0);  observe(en_a);
    expect_v("arst_st", 32'd0);  observe(st_a);
    expect_v("arst_ud", 32'd1);  observe(ud_a);
    expect_v("arst_clr", 32'd1); observe(clr_a);
    step(2);
    reset = 1'b1;
    step(2);

    // AUTO_STOP: terminal count at tick suppresses enable and enters DONE.
    expect_v("b_run_st", 32'd1);
    press(1'b1, 3'b001, 5);
    observe(st_b);
    expect_v("b_en_seen", 32'd1);
    wait_en(1'b1, 8, c1, seen);
    observe(seen);
    tc_up_b = 1'b1;
    step(4);
    expect_v("b_done_st", 32'd3); observe(st_b);
    expect_v("b_done_en", 32'd0); observe(en_b);
    expect_v("b_done_quiet", 32'd0);
    quiet(1'b1, 8, any);
    observe(any);
    w = cyc;
    press(1'b1, 3'b100, 4);
    expect_v("b_clr_seen", 32'd1);
    wait_clr(1'b1, 4, c1, seen);
    observe(seen);
    expect_v("b_clr_lat", 32'd5);
    observe(c1 - w);
    expect_v("b_clr_st", 32'd0);
    observe(st_b);
    expect_v("b_clr_width", 32'd1);
    step(1);
    observe(clr_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
